fp_divider: RTL

- Sequential IEEE-754 single-precision divider (o_res = i_a / i_b).
- Sits beside the floating-point multiplier in the arithmetic datapath and handles the same operand classes: zero, subnormal, normal, infinity and NaN.
- The mantissa quotient is produced by an iterative restoring divider at 1 bit per clock.
- Rounding is truncation (round-toward-zero), matching the multiplier.

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_divider_lzc24.sv | 13 +
 rtl/fp_divider.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision floating-point datapath:
// operand class codes, bias, canned results and divider FSM states.
package fp_pkg;
  localparam int          FP_BIAS = 127;
  localparam logic [31:0] QNAN    = 32'hFFFF_FFFF;
  localparam logic [31:0] PINF    = 32'h7F80_0000;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'b000,
    CLS_SUBN = 3'b001,
    CLS_NORM = 3'b011,
    CLS_INF  = 3'b100,
    CLS_NAN  = 3'b110
  } fp_class_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_DIVIDE,
    ST_NORM,
    ST_DONE
  } div_state_e;

  function automatic fp_class_e fp_classify(input logic [31:0] x);
    fp_class_e cls;
    if (x[30:23] == 8'hFF)      cls = (x[22:0] == '0) ? CLS_INF : CLS_NAN;
    else if (x[30:23] == 8'h00) cls = (x[22:0] == '0) ? CLS_ZERO : CLS_SUBN;
    else                        cls = CLS_NORM;
    return cls;
  endfunction
endpackage

// File: rtl/fp_divider_lzc24.sv
// 24-bit leading-zero counter; an all-zero input reports 24.
module lzc24 (
  input  logic [23:0] i_val,
  output logic [4:0]  o_cnt
);
  always_comb begin
    o_cnt = 5'd24;
    // scanning upward lets the most significant set bit win
    for (int i = 0; i < 24; i++) begin
      if (i_val[i]) o_cnt = 5'(23 - i);
    end
  end
endmodule

// File: rtl/fp_divider.sv
// Sequential IEEE-754 single-precision divider: restoring mantissa division at
// one quotient bit per clock, truncating rounding, fixed 28-cycle latency.
module fp_divider #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = fp_pkg::FP_BIAS
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_res,
  output logic        o_overflow,
  output logic        o_underflow,
  output logic        o_div_by_zero
);
  import fp_pkg::*;

  localparam int         SIG_W     = MAN_W + 1;
  localparam int         Q_W       = MAN_W + 2;
  localparam int         R_W       = MAN_W + 3;
  localparam logic [4:0] LAST_ITER = 5'(Q_W - 1);

  div_state_e        state_reg;
  logic [31:0]       a_reg, b_reg;
  fp_class_e         cls_a_reg, cls_b_reg;
  logic              sign_reg;
  logic signed [9:0] e_q_reg;
  logic [R_W-1:0]    rem_reg;
  logic [Q_W-1:0]    quo_reg;
  logic [SIG_W-1:0]  div_reg;
  logic [4:0]        cnt_reg;

  logic [1:0][31:0]      op;
  logic [1:0][SIG_W-1:0] sig_u;
  logic [1:0][9:0]       exp_u;
  logic [1:0][2:0]       cls_u;

  assign op[0] = a_reg;
  assign op[1] = b_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    logic [EXP_W-1:0] e_fld;
    logic [MAN_W-1:0] m_fld;
    logic [SIG_W-1:0] raw;
    logic [4:0]       lz;

    assign e_fld     = op[gi][MAN_W +: EXP_W];
    assign m_fld     = op[gi][MAN_W-1:0];
    assign raw       = {1'b0, m_fld};
    assign cls_u[gi] = fp_classify(op[gi]);

    lzc24 u_lzc (
      .i_val (raw),
      .o_cnt (lz)
    );

    // subnormals are left-justified so the divider always sees a leading one
    assign sig_u[gi] = (cls_u[gi] == CLS_SUBN) ? raw << lz : {1'b1, m_fld};
    assign exp_u[gi] = (cls_u[gi] == CLS_SUBN) ? 10'd1 - 10'(lz) : 10'(e_fld);
  end

  logic signed [9:0] e_q_calc;
  assign e_q_calc = $signed(exp_u[0]) - $signed(exp_u[1]) + $signed(10'(BIAS));

  logic             rem_ge;
  logic [R_W-2:0]   rem_sub;
  assign rem_ge  = rem_reg >= R_W'(div_reg);
  assign rem_sub = (R_W-1)'(rem_reg - R_W'(div_reg));

  logic a_zero, a_inf, a_nan, a_fin_nz, b_zero, b_inf, b_nan;
  assign a_zero   = cls_a_reg == CLS_ZERO;
  assign a_inf    = cls_a_reg == CLS_INF;
  assign a_nan    = cls_a_reg == CLS_NAN;
  assign a_fin_nz = (cls_a_reg == CLS_SUBN) || (cls_a_reg == CLS_NORM);
  assign b_zero   = cls_b_reg == CLS_ZERO;
  assign b_inf    = cls_b_reg == CLS_INF;
  assign b_nan    = cls_b_reg == CLS_NAN;

  logic signed [9:0] e_n;
  logic [SIG_W-1:0]  s_n;
  logic [9:0]        sh_n;
  logic [MAN_W-1:0]  sub_man;
  logic [31:0]       sgn_word, res_next;
  logic              ovf_next, unf_next, dbz_next;

  assign sgn_word = {sign_reg, 31'd0};

  always_comb begin
    e_n      = quo_reg[Q_W-1] ? e_q_reg : e_q_reg - 10'sd1;
    s_n      = quo_reg[Q_W-1] ? quo_reg[Q_W-1:1] : quo_reg[SIG_W-1:0];
    sh_n     = 10'd1 - e_n;
    sub_man  = (sh_n >= 10'(SIG_W)) ? '0 : MAN_W'(s_n >> sh_n[4:0]);
    res_next = sgn_word;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    dbz_next = 1'b0;
    // operand-class special cases take priority over the computed quotient
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      res_next = QNAN;
    end else if (a_fin_nz && b_zero) begin
      res_next = sgn_word | PINF;
      dbz_next = 1'b1;
    end else if (a_inf) begin
      res_next = sgn_word | PINF;
    end else if (a_zero || b_inf) begin
      res_next = sgn_word;
    end else if (e_n >= 10'sd255) begin
      res_next = sgn_word | PINF;
      ovf_next = 1'b1;
    end else if (e_n >= 10'sd1) begin
      res_next = {sign_reg, e_n[7:0], s_n[MAN_W-1:0]};
    end else begin
      res_next = {sign_reg, 8'd0, sub_man};
      unf_next = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      cls_a_reg     <= CLS_ZERO;
      cls_b_reg     <= CLS_ZERO;
      sign_reg      <= 1'b0;
      e_q_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      div_reg       <= '0;
      cnt_reg       <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_res         <= '0;
      o_overflow    <= 1'b0;
      o_underflow   <= 1'b0;
      o_div_by_zero <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            a_reg         <= i_a;
            b_reg         <= i_b;
            o_busy        <= 1'b1;
            o_overflow    <= 1'b0;
            o_underflow   <= 1'b0;
            o_div_by_zero <= 1'b0;
            state_reg     <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          cls_a_reg <= fp_class_e'(cls_u[0]);
          cls_b_reg <= fp_class_e'(cls_u[1]);
          sign_reg  <= a_reg[31] ^ b_reg[31];
          e_q_reg   <= e_q_calc;
          rem_reg   <= R_W'(sig_u[0]);
          div_reg   <= sig_u[1];
          quo_reg   <= '0;
          cnt_reg   <= '0;
          state_reg <= ST_DIVIDE;
        end
        ST_DIVIDE: begin
          rem_reg <= rem_ge ? {rem_sub, 1'b0} : {rem_reg[R_W-2:0], 1'b0};
          quo_reg <= {quo_reg[Q_W-2:0], rem_ge};
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == LAST_ITER) state_reg <= ST_NORM;
        end
        ST_NORM: begin
          o_res         <= res_next;
          o_overflow    <= ovf_next;
          o_underflow   <= unf_next;
          o_div_by_zero <= dbz_next;
          o_done        <= 1'b1;
          o_busy        <= 1'b0;
          state_reg     <= ST_DONE;
        end
        ST_DONE:  state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule
